// File: rtl/calc3_multi_port_if.sv
`default_nettype none
// ============================================================================
// calc3_multi_port_if : request/response bus bundle for the calc3 core
// Revision 1.0
// ============================================================================
interface calc3_multi_port_if #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 2
);
   logic [N_PORTS*4-1:0]      req_cmd_in;
   logic [N_PORTS*DATA_W-1:0] req_data_in;
   logic [N_PORTS*TAG_W-1:0]  req_tag_in;
   logic [N_PORTS-1:0]        req_busy;
   logic [N_PORTS*2-1:0]      out_resp;
   logic [N_PORTS*DATA_W-1:0] out_data;
   logic [N_PORTS*TAG_W-1:0]  out_tag;
   logic [N_PORTS-1:0]        out_ready;

   modport master (
      output req_cmd_in, req_data_in, req_tag_in, out_ready,
      input  req_busy, out_resp, out_data, out_tag
   );

   modport slave (
      input  req_cmd_in, req_data_in, req_tag_in, out_ready,
      output req_busy, out_resp, out_data, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/calc3_multi_port.sv
`default_nettype none
// ============================================================================
// calc3_multi_port : N-port calculator, shared single-cycle ALU, RR arbiter
// Revision 1.0
// ============================================================================
module calc3_multi_port #(
   parameter int N_PORTS    = 4,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 2,
   parameter int RESP_DEPTH = 4
) (
   input  wire logic         c_clk,
   input  wire logic         reset,
   calc3_multi_port_if.slave bus
);
   localparam int c_PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int c_SH_W  = $clog2(DATA_W);
   localparam int c_FP_W  = $clog2(RESP_DEPTH);
   localparam int c_CNT_W = c_FP_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t              r_state     [N_PORTS];
   state_t              w_state_nxt [N_PORTS];
   logic [3:0]          r_cmd       [N_PORTS];
   logic [DATA_W-1:0]   r_op1       [N_PORTS];
   logic [DATA_W-1:0]   r_op2       [N_PORTS];
   logic [TAG_W-1:0]    r_tag       [N_PORTS];
   logic [1:0]          r_fq_resp   [N_PORTS][RESP_DEPTH];
   logic [DATA_W-1:0]   r_fq_data   [N_PORTS][RESP_DEPTH];
   logic [TAG_W-1:0]    r_fq_tag    [N_PORTS][RESP_DEPTH];
   logic [c_FP_W-1:0]   r_wptr      [N_PORTS];
   logic [c_FP_W-1:0]   r_rptr      [N_PORTS];
   logic [c_CNT_W-1:0]  r_count     [N_PORTS];
   logic [c_PTR_W-1:0]  r_rr;

   logic [N_PORTS-1:0]  w_full, w_busy, w_accept, w_pend, w_push, w_pop;
   logic                w_gnt_vld;
   logic [c_PTR_W-1:0]  w_gnt_idx;
   int                  w_scan;
   logic [3:0]          w_g_cmd;
   logic [DATA_W-1:0]   w_g_op1, w_g_op2, w_alu_data;
   logic [DATA_W:0]     w_sum;
   logic [1:0]          w_alu_resp;

   always_comb begin
      w_full   = '0;
      w_busy   = '0;
      w_accept = '0;
      w_pend   = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         w_full[p]   = (r_count[p] == c_CNT_W'(RESP_DEPTH));
         w_busy[p]   = (r_state[p] != ST_IDLE) || w_full[p];
         w_accept[p] = (bus.req_cmd_in[4*p +: 4] != 4'd0) && !w_busy[p];
         w_pend[p]   = (r_state[p] == ST_PEND);
      end
   end

   // Round robin: first pending port at or after the pointer wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_scan    = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         w_scan = (int'(r_rr) + k) % N_PORTS;
         if (!w_gnt_vld && w_pend[w_scan]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = c_PTR_W'(w_scan);
         end
      end
   end

   always_comb begin
      w_push = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         w_push[p] = w_gnt_vld && (w_gnt_idx == c_PTR_W'(p));
      end
   end

   always_comb begin
      w_g_cmd    = r_cmd[w_gnt_idx];
      w_g_op1    = r_op1[w_gnt_idx];
      w_g_op2    = r_op2[w_gnt_idx];
      w_sum      = {1'b0, w_g_op1} + {1'b0, w_g_op2};
      w_alu_resp = 2'd2;
      w_alu_data = '0;
      case (w_g_cmd)
         4'd1: if (!w_sum[DATA_W]) begin
            w_alu_resp = 2'd1;
            w_alu_data = w_sum[DATA_W-1:0];
         end
         4'd2: if (w_g_op2 <= w_g_op1) begin
            w_alu_resp = 2'd1;
            w_alu_data = w_g_op1 - w_g_op2;
         end
         4'd5: begin
            w_alu_resp = 2'd1;
            w_alu_data = w_g_op1 << w_g_op2[c_SH_W-1:0];
         end
         4'd6: begin
            w_alu_resp = 2'd1;
            w_alu_data = w_g_op1 >> w_g_op2[c_SH_W-1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         w_state_nxt[p] = r_state[p];
         case (r_state[p])
            ST_IDLE: if (w_accept[p]) w_state_nxt[p] = ST_OP2;
            ST_OP2:  w_state_nxt[p] = ST_PEND;
            ST_PEND: if (w_push[p]) w_state_nxt[p] = ST_IDLE;
            default: w_state_nxt[p] = ST_IDLE;
         endcase
      end
   end

   // Show-ahead head; an empty FIFO presents all-zero outputs.
   always_comb begin
      bus.out_resp = '0;
      bus.out_data = '0;
      bus.out_tag  = '0;
      bus.req_busy = w_busy;
      w_pop        = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (r_count[p] != '0) begin
            bus.out_resp[2*p +: 2]           = r_fq_resp[p][r_rptr[p]];
            bus.out_data[DATA_W*p +: DATA_W] = r_fq_data[p][r_rptr[p]];
            bus.out_tag[TAG_W*p +: TAG_W]    = r_fq_tag[p][r_rptr[p]];
         end
         w_pop[p] = bus.out_ready[p] && (bus.out_resp[2*p +: 2] != 2'd0);
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_rr <= '0;
         for (int p = 0; p < N_PORTS; p++) begin
            r_state[p] <= ST_IDLE;
            r_cmd[p]   <= '0;
            r_op1[p]   <= '0;
            r_op2[p]   <= '0;
            r_tag[p]   <= '0;
            r_wptr[p]  <= '0;
            r_rptr[p]  <= '0;
            r_count[p] <= '0;
         end
      end else begin
         if (w_gnt_vld) begin
            r_rr <= (w_gnt_idx == c_PTR_W'(N_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
         for (int p = 0; p < N_PORTS; p++) begin
            r_state[p] <= w_state_nxt[p];
            if (w_accept[p]) begin
               r_cmd[p] <= bus.req_cmd_in[4*p +: 4];
               r_op1[p] <= bus.req_data_in[DATA_W*p +: DATA_W];
               r_tag[p] <= bus.req_tag_in[TAG_W*p +: TAG_W];
            end
            if (r_state[p] == ST_OP2) begin
               r_op2[p] <= bus.req_data_in[DATA_W*p +: DATA_W];
            end
            if (w_push[p]) r_wptr[p] <= r_wptr[p] + 1'b1;
            if (w_pop[p])  r_rptr[p] <= r_rptr[p] + 1'b1;
            if (w_push[p] && !w_pop[p]) begin
               r_count[p] <= r_count[p] + 1'b1;
            end else if (w_pop[p] && !w_push[p]) begin
               r_count[p] <= r_count[p] - 1'b1;
            end
         end
      end
   end

   // Payload storage needs no reset: the occupancy count gates visibility.
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (w_push[p]) begin
            r_fq_resp[p][r_wptr[p]] <= w_alu_resp;
            r_fq_data[p][r_wptr[p]] <= w_alu_data;
            r_fq_tag[p][r_wptr[p]]  <= r_tag[p];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_calc3_multi_port.sv
`default_nettype none
// ============================================================================
// tb_calc3_multi_port : directed + random stimulus against a queue-based model
// Revision 1.0
// ============================================================================
module tb_calc3_multi_port;
   localparam int NP  = 4;
   localparam int DW  = 32;
   localparam int TW  = 2;
   localparam int DEP = 4;

   logic c_clk = 1'b0;
   logic reset = 1'b0;
   always #5 c_clk = ~c_clk;

   calc3_multi_port_if #(.N_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

   calc3_multi_port #(.N_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .RESP_DEPTH(DEP)) dut (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [1:0]    resp;
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
   } rsp_t;

   logic [3:0]    s_cmd [NP];
   logic [DW-1:0] s_dat [NP];
   logic [TW-1:0] s_tag [NP];
   logic          s_rdy [NP];

   rsp_t          mq    [NP][$];
   bit            m_infl[NP];
   int            m_acc [NP];
   logic [3:0]    m_cmd [NP];
   logic [DW-1:0] m_a   [NP];
   logic [DW-1:0] m_b   [NP];
   logic [TW-1:0] m_tag [NP];
   int            m_rr;
   int            m_cyc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rsp_t alu(input logic [3:0] c, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [TW-1:0] t);
      rsp_t        r;
      longint      s;
      int          n;
      r.tag  = t;
      r.resp = 2'd2;
      r.data = '0;
      n      = int'(b % 32);
      case (c)
         4'd1: begin
            s = longint'(a) + longint'(b);
            if (s <= 64'h0000_0000_FFFF_FFFF) begin r.resp = 2'd1; r.data = s[31:0]; end
         end
         4'd2: begin
            s = longint'(a) - longint'(b);
            if (s >= 0) begin r.resp = 2'd1; r.data = s[31:0]; end
         end
         4'd5: begin r.resp = 2'd1; r.data = DW'(longint'(a) * (64'd1 << n)); end
         4'd6: begin r.resp = 2'd1; r.data = DW'(longint'(a) / (64'd1 << n)); end
         default: ;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mq[p].delete();
         m_infl[p] = 1'b0;
         m_acc[p]  = 0;
      end
      m_rr  = 0;
      m_cyc = 0;
   endtask

   function automatic bit model_busy(input int p);
      return m_infl[p] || (mq[p].size() == DEP);
   endfunction

   // Applies one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      bit busy[NP];
      int g;
      int idx;
      g = -1;
      for (int p = 0; p < NP; p++) busy[p] = model_busy(p);
      for (int k = 0; k < NP; k++) begin
         idx = (m_rr + k) % NP;
         if (g < 0 && m_infl[idx] && m_cyc >= m_acc[idx] + 2) g = idx;
      end
      for (int p = 0; p < NP; p++) begin
         if (s_rdy[p] && mq[p].size() > 0) void'(mq[p].pop_front());
      end
      if (g >= 0) begin
         mq[g].push_back(alu(m_cmd[g], m_a[g], m_b[g], m_tag[g]));
         m_infl[g] = 1'b0;
         m_rr      = (g + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
         if (m_infl[p] && m_cyc == m_acc[p] + 1) m_b[p] = s_dat[p];
         if (!busy[p] && s_cmd[p] != 4'd0) begin
            m_infl[p] = 1'b1;
            m_acc[p]  = m_cyc;
            m_cmd[p]  = s_cmd[p];
            m_a[p]    = s_dat[p];
            m_tag[p]  = s_tag[p];
         end
      end
      m_cyc++;
   endtask

   task automatic pack();
      for (int p = 0; p < NP; p++) begin
         bus.req_cmd_in[4*p +: 4]    = s_cmd[p];
         bus.req_data_in[DW*p +: DW] = s_dat[p];
         bus.req_tag_in[TW*p +: TW]  = s_tag[p];
         bus.out_ready[p]            = s_rdy[p];
      end
   endtask

   task automatic check_outputs();
      rsp_t h;
      for (int p = 0; p < NP; p++) begin
         h = '0;
         if (mq[p].size() > 0) h = mq[p][0];
         check_val($sformatf("resp[%0d]", p), 128'(bus.out_resp[2*p +: 2]), 128'(h.resp));
         check_val($sformatf("data[%0d]", p), 128'(bus.out_data[DW*p +: DW]), 128'(h.data));
         check_val($sformatf("tag[%0d]", p), 128'(bus.out_tag[TW*p +: TW]), 128'(h.tag));
         check_val($sformatf("busy[%0d]", p), 128'(bus.req_busy[p]), 128'(model_busy(p)));
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cycle();
      pack();
      @(posedge c_clk);
      if (reset) model_edge();
      #1;
      check_outputs();
      @(negedge c_clk);
   endtask

   task automatic issue(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] t);
      s_cmd[p] = c; s_dat[p] = a; s_tag[p] = t;
      cycle();
      s_cmd[p] = 4'd0; s_dat[p] = b;
      cycle();
      s_dat[p] = '0;
      cycle();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_resp"}, 128'(bus.out_resp), 128'(0));
      check_val({tag, "_data"}, 128'(bus.out_data), 128'(0));
      check_val({tag, "_tag"},  128'(bus.out_tag),  128'(0));
      check_val({tag, "_busy"}, 128'(bus.req_busy), 128'(0));
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset = 1'b0;
      #1 check_all_zero(tag);
      model_reset();
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   function automatic logic [3:0] rand_cmd();
      case ($urandom_range(0, 9))
         0, 1, 2: return 4'd0;
         3:       return 4'd1;
         4:       return 4'd2;
         5:       return 4'd5;
         6:       return 4'd6;
         7:       return 4'd3;
         8:       return 4'd15;
         default: return 4'd1;
      endcase
   endfunction

   function automatic logic [DW-1:0] rand_data();
      case ($urandom_range(0, 3))
         0:       return DW'($urandom_range(0, 40));
         1:       return 32'hFFFF_FFFF - DW'($urandom_range(0, 40));
         2:       return 32'h8000_0000;
         default: return DW'($urandom);
      endcase
   endfunction

   int rdy_bias;

   initial begin
      for (int p = 0; p < NP; p++) begin
         s_cmd[p] = '0; s_dat[p] = '0; s_tag[p] = '0; s_rdy[p] = 1'b1;
      end
      model_reset();
      pack();
      @(negedge c_clk);
      check_all_zero("reset");
      reset = 1'b1;
      cycle();

      // Basic add, then timing of the result head.
      issue(0, 4'd1, 32'h30, 32'h20, 2'd1);
      check_val("t1_data", 128'(bus.out_data[31:0]), 128'(32'h50));
      check_val("t1_resp", 128'(bus.out_resp[1:0]), 128'(2'd1));
      cycle();

      // Error responses in issue order.
      issue(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2);
      issue(0, 4'd2, 32'h5, 32'h7, 2'd3);
      issue(0, 4'd3, 32'h9, 32'h9, 2'd0);
      cycle();

      // Four simultaneous shifts, two rounds.
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NP; p++) begin s_cmd[p] = 4'd5; s_dat[p] = 32'h1; s_tag[p] = TW'(p); end
         cycle();
         for (int p = 0; p < NP; p++) begin s_cmd[p] = 4'd0; s_dat[p] = 32'h4; end
         cycle();
         for (int p = 0; p < NP; p++) s_dat[p] = '0;
         repeat (5) cycle();
      end

      // Fill P1 with ready held low, then drain.
      s_rdy[1] = 1'b0;
      for (int i = 1; i <= 4; i++) issue(1, 4'd1, DW'(i), DW'(i), TW'(i));
      repeat (3) cycle();
      check_val("t4_head", 128'(bus.out_data[63:32]), 128'(32'd2));
      check_val("t4_busy", 128'(bus.req_busy[1]), 128'(1'b1));
      s_rdy[1] = 1'b1;
      repeat (6) cycle();

      // Reset while P2 has a pending operation.
      s_cmd[2] = 4'd1; s_dat[2] = 32'd7; s_tag[2] = 2'd2;
      cycle();
      s_cmd[2] = 4'd0; s_dat[2] = 32'd9;
      cycle();
      s_dat[2] = '0;
      async_reset_pulse("t5");
      repeat (4) cycle();
      issue(2, 4'd2, 32'd10, 32'd3, 2'd1);
      cycle();

      // Shift-amount boundary.
      issue(0, 4'd6, 32'h8000_0000, 32'd31, 2'd0);
      check_val("t6_shr31", 128'(bus.out_data[31:0]), 128'(32'h1));
      issue(0, 4'd6, 32'h8000_0000, 32'd33, 2'd3);
      check_val("t6_shr33", 128'(bus.out_data[31:0]), 128'(32'h4000_0000));
      cycle();

      rdy_bias = 4;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) rdy_bias = $urandom_range(0, 4);
         for (int p = 0; p < NP; p++) begin
            s_cmd[p] = rand_cmd();
            s_dat[p] = rand_data();
            s_tag[p] = TW'($urandom);
            s_rdy[p] = ($urandom_range(0, 3) < rdy_bias);
         end
         if (c == 2000) async_reset_pulse("rand_rst");
         cycle();
      end

      for (int p = 0; p < NP; p++) begin s_cmd[p] = '0; s_rdy[p] = 1'b1; end
      repeat (20) cycle();
      check_all_zero("drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
